// File: rtl/rram_train_seq.sv
// Control-pin sequencer for the 3-layer RRAM training array: one sample per
// handshake, stepped through forward (L1, L2, L3), error and backprop phases.
module rram_train_seq #(
    parameter int SET_CYC    = 16,
    parameter int SETTLE_CYC = 8,
    parameter int ERR_CYC    = 4,
    parameter int BACK_CYC   = 32,
    parameter int CW         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic        abort,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_x,
    input  logic        s_label,
    output logic [5:0]  Dwl,
    output logic [5:0]  Dsl,
    output logic [5:0]  Dbl,
    output logic        Dset,
    output logic        Dback,
    output logic        Dlabel,
    output logic        busy,
    output logic        done,
    output logic        init_done,
    output logic [15:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_FWD1, S_FWD2, S_FWD3, S_ERR, S_BACK, S_DONE
    } state_t;

    localparam logic [CW-1:0] SET_LD    = CW'(SET_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] ERR_LD    = CW'(ERR_CYC - 1);
    localparam logic [CW-1:0] BACK_LD   = CW'(BACK_CYC - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      x_reg, x_next;
    logic            label_reg, label_next;
    logic            init_done_reg, init_done_next;
    logic [15:0]     sample_cnt_reg, sample_cnt_next;
    logic [2:0]      layer_next;
    logic [5:0]      lmask_next;
    logic            phase_end;

    assign phase_end  = (cnt_reg == '0);
    assign init_done  = init_done_reg;
    assign sample_cnt = sample_cnt_reg;
    // Ready is gated by init_req directly so an IDLE cycle heading to SET never accepts.
    assign s_ready    = (state_reg == S_IDLE) && init_done_reg && !init_req;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        x_next          = x_reg;
        label_next      = label_reg;
        init_done_next  = init_done_reg;
        sample_cnt_next = sample_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (init_req || !init_done_reg) begin
                    state_next = S_SET;
                    cnt_next   = SET_LD;
                end else if (s_valid) begin
                    state_next = S_FWD1;
                    cnt_next   = SETTLE_LD;
                    x_next     = s_x;
                    label_next = s_label;
                end
            end
            S_SET: begin
                if (phase_end) begin
                    state_next     = S_IDLE;
                    init_done_next = 1'b1;
                end else cnt_next = cnt_reg - CW'(1);
            end
            S_FWD1: begin
                if (phase_end) begin
                    state_next = S_FWD2;
                    cnt_next   = SETTLE_LD;
                end else cnt_next = cnt_reg - CW'(1);
            end
            S_FWD2: begin
                if (phase_end) begin
                    state_next = S_FWD3;
                    cnt_next   = SETTLE_LD;
                end else cnt_next = cnt_reg - CW'(1);
            end
            S_FWD3: begin
                if (phase_end) begin
                    state_next = S_ERR;
                    cnt_next   = ERR_LD;
                end else cnt_next = cnt_reg - CW'(1);
            end
            S_ERR: begin
                if (phase_end) begin
                    state_next = S_BACK;
                    cnt_next   = BACK_LD;
                end else cnt_next = cnt_reg - CW'(1);
            end
            S_BACK: begin
                if (phase_end) state_next = S_DONE;
                else cnt_next = cnt_reg - CW'(1);
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Abort wins over any phase end and never completes a sample.
        if (abort && state_reg != S_IDLE) begin
            state_next     = S_IDLE;
            cnt_next       = '0;
            init_done_next = init_done_reg;
        end
        if (state_next == S_DONE)
            sample_cnt_next = sample_cnt_reg + 16'd1;
    end

    // Layer flags ordered {L1, L2, L3}; each drives its own pin pair.
    assign layer_next = {state_next == S_FWD1, state_next == S_FWD2, state_next == S_FWD3};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_layer
            assign lmask_next[2*gi +: 2] = {2{layer_next[gi]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            x_reg          <= '0;
            label_reg      <= 1'b0;
            init_done_reg  <= 1'b0;
            sample_cnt_reg <= '0;
            Dwl            <= '0;
            Dsl            <= '0;
            Dbl            <= '0;
            Dset           <= 1'b0;
            Dback          <= 1'b0;
            Dlabel         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            x_reg          <= x_next;
            label_reg      <= label_next;
            init_done_reg  <= init_done_next;
            sample_cnt_reg <= sample_cnt_next;
            Dwl            <= lmask_next;
            Dsl            <= lmask_next;
            Dbl            <= lmask_next & {x_next, 4'b1111};
            Dset           <= (state_next == S_SET);
            Dback          <= (state_next == S_BACK);
            Dlabel         <= label_next && (state_next == S_ERR || state_next == S_BACK);
            busy           <= (state_next != S_IDLE);
            done           <= (state_next == S_DONE);
        end
    end

endmodule
